// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RISC-V pipeline: stalls, flushes, E-stage forwarding and the MUL hold FSM.
// Optional feature macro: HAZARD_FWD_EN (defined = operand forwarding, undefined = stall on every RAW hazard).
module hazard_ctrl_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       RegWriteE,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MulStartE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MulDoneE
);

  localparam int CNT_W      = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int CNT_INIT_I = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic       mul_stall_s;
  logic       mul_done_s;
  logic       lw_stall_s;
  logic       raw_stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // A matching write in M takes precedence over W because it is the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Busy FSM state and countdown register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: the counter covers the stalled cycles after the first one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_stall_s = 1'b0;
    mul_done_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulStartE) begin
          if (MUL_LAT > 1) begin
            mul_stall_s = 1'b1;
            state_d     = BUSY;
            cnt_d       = CNT_INIT;
          end else begin
            mul_done_s  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_ZERO) begin
          mul_stall_s = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
        end else begin
          mul_done_s  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Load-use and RAW hazard detection against the instruction in D.
  always_comb begin
    lw_stall_s = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                 ((RdE == Rs1D) || (RdE == Rs2D));
`ifdef HAZARD_FWD_EN
    raw_stall_s = 1'b0;
    fwd_a_s     = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b_s     = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
`else
    // W is not checked: the register file writes before it is read.
    raw_stall_s = ((Rs1D != 5'd0) && ((RegWriteE && (RdE == Rs1D)) ||
                                      (RegWriteM && (RdM == Rs1D)))) ||
                  ((Rs2D != 5'd0) && ((RegWriteE && (RdE == Rs2D)) ||
                                      (RegWriteM && (RdM == Rs2D))));
    fwd_a_s     = 2'b00;
    fwd_b_s     = 2'b00;
`endif
  end

`ifdef HAZARD_FWD_EN
  logic unused_s;
  assign unused_s = RegWriteE;
`else
  logic unused_s;
  assign unused_s = ^{Rs1E, Rs2E, RdW, RegWriteW};
`endif

  // Output decode; a held E must never be cleared, so mul_stall masks the flushes.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    MulDoneE  = 1'b0;
    if (rst) begin
      StallF = 1'b0;
    end else begin
      StallF    = lw_stall_s || raw_stall_s || mul_stall_s;
      StallD    = lw_stall_s || raw_stall_s || mul_stall_s;
      StallE    = mul_stall_s;
      FlushM    = mul_stall_s;
      FlushD    = PCSrcE && !mul_stall_s;
      FlushE    = (lw_stall_s || raw_stall_s || PCSrcE) && !mul_stall_s;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
      MulDoneE  = mul_done_s;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: stimulus pushes expected output vectors, a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW, PCSrcE, MulStartE;
  logic [1:0] ResultSrcE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDoneE;
  logic [1:0] ForwardAE, ForwardBE;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic [10:0] exp_q[$];
  string       nm_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        drain_fail = 1'b0;
  logic [10:0] mon_exp;
  logic [10:0] mon_act;
  string       mon_nm;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MUL_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MulDoneE(MulDoneE)
  );

  // Vector order: StallF StallD StallE FlushD FlushE FlushM ForwardAE ForwardBE MulDoneE
  function automatic logic [10:0] ex(input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic fm,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic md);
    return {sf, sd, se, fd, fe, fm, fa, fb, md};
  endfunction

  task automatic expect_now(input string nm, input logic [10:0] e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ResultSrcE = 2'b00; PCSrcE = 1'b0; MulStartE = 1'b0;
  endtask

  // Monitor: compares the DUT vector against the scoreboard and guards the branch-during-MUL rule.
  always @(negedge clk) begin
    mon_act = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, MulDoneE};
    if (!rst && PCSrcE && StallE) begin
      errors = errors + 1;
      $display("FAIL branch_during_mul: PCSrcE=%b while StallE=%b, required no overlap", PCSrcE, StallE);
    end
    if (drain_fail) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      drain_fail = 1'b0;
    end
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = nm_q.pop_front();
      checks  = checks + 1;
      if (mon_act !== mon_exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %b, expected %b", mon_nm, mon_act, mon_exp);
      end
    end
  end

  initial begin
    int drain;
    clr_in();
    rst = 1'b1;
    MulStartE = 1'b1; PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
    next_cyc(); next_cyc();
    expect_now("reset_outputs_zero", 11'd0);
    next_cyc();
    rst = 1'b0;
    clr_in();
    expect_now("post_reset_idle", 11'd0);
    next_cyc();

    // Forwarding
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
    expect_now("fwd_a_m_over_w", ex(0, 0, 0, 0, 0, 0, FWD ? 2'b10 : 2'b00, 2'b00, 0));
    next_cyc();
    RdM = 5'd0;
    expect_now("fwd_a_from_w", ex(0, 0, 0, 0, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00, 0));
    next_cyc();
    RdW = 5'd0;
    expect_now("fwd_x0_never", 11'd0);
    next_cyc();
    RdM = 5'd6; Rs2E = 5'd6; RdW = 5'd5;
    expect_now("fwd_a_w_b_m", ex(0, 0, 0, 0, 0, 0, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00, 0));
    next_cyc();
    RegWriteM = 1'b0;
    expect_now("fwd_m_disabled", ex(0, 0, 0, 0, 0, 0, FWD ? 2'b01 : 2'b00, 2'b00, 0));
    next_cyc();
    clr_in();

    // Load-use
    ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    expect_now("load_use_rs2", ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    RdE = 5'd0;
    expect_now("load_use_x0", 11'd0);
    next_cyc();
    RdE = 5'd8; Rs1D = 5'd8; Rs2D = 5'd0;
    expect_now("load_use_rs1", ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    clr_in();

    // Branch
    PCSrcE = 1'b1;
    expect_now("branch_flush", ex(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
    expect_now("branch_plus_load_use", ex(1, 1, 0, 1, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    clr_in();

    // MUL, four cycles in E
    MulStartE = 1'b1;
    expect_now("mul_stall_1", ex(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    next_cyc();
    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9;
    expect_now("mul_stall_2_lw_noflush", ex(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    next_cyc();
    ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;
    expect_now("mul_stall_3", ex(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    next_cyc();
    expect_now("mul_done_4", ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    next_cyc();
    MulStartE = 1'b0;
    expect_now("mul_after_idle", 11'd0);
    next_cyc();

    // Reset during BUSY aborts the MUL
    MulStartE = 1'b1;
    expect_now("abort_stall_1", ex(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
    next_cyc();
    rst = 1'b1; MulStartE = 1'b0;
    expect_now("abort_reset_zero", 11'd0);
    next_cyc();
    rst = 1'b0;
    expect_now("abort_idle_no_done", 11'd0);
    next_cyc();
    expect_now("abort_idle_no_done_2", 11'd0);
    next_cyc();
    MulStartE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_now("remul_stall", ex(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0));
      next_cyc();
    end
    expect_now("remul_done", ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    next_cyc();
    clr_in();

    // RAW hazards without forwarding
    RegWriteE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
    expect_now("raw_e_stage", FWD ? 11'd0 : ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    RegWriteE = 1'b0; RdE = 5'd0; RegWriteM = 1'b1; RdM = 5'd3;
    expect_now("raw_m_stage", FWD ? 11'd0 : ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    RegWriteM = 1'b0; RegWriteW = 1'b1; RdW = 5'd3;
    expect_now("raw_w_no_stall", 11'd0);
    next_cyc();
    RegWriteW = 1'b0; RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    expect_now("raw_x0_no_stall", 11'd0);
    next_cyc();
    RdE = 5'd4; Rs2D = 5'd4;
    expect_now("raw_rs2", FWD ? 11'd0 : ex(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0));
    next_cyc();
    clr_in();

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      next_cyc();
      drain++;
    end
    if (exp_q.size() > 0) begin
      drain_fail = 1'b1;
      next_cyc();
    end
    next_cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
